// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types and constants for the xor cipher controller
package xor_cipher_pkg;

    localparam int KEY_LEN_MAX = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] kidx_t;
    typedef byte_t key_bank_t [KEY_LEN_MAX];

    function automatic byte_t rotl1(input byte_t b);
        return {b[6:0], b[7]};
    endfunction

endpackage

// File: rtl/xor_cipher_ctrl_if.sv
// rtl/xor_cipher_ctrl_if.sv - byte-in / ciphertext-out handshake bundle
//
// Signals:
//   in_valid/in_is_key/in_data/in_ready : input byte stream (key or plaintext)
//   resync                              : index reset / schedule restore pulse
//   out_valid/out_data/out_ready        : ciphertext stream
//   key_loaded/err                      : status
// Modports: master = pin-mux side driving bytes, slave = controller.
interface xor_cipher_ctrl_if;
    import xor_cipher_pkg::*;

    logic  in_valid;
    logic  in_is_key;
    byte_t in_data;
    logic  in_ready;
    logic  resync;
    logic  out_valid;
    byte_t out_data;
    logic  out_ready;
    logic  key_loaded;
    logic  err;

    modport master (
        output in_valid, in_is_key, in_data, resync, out_ready,
        input  in_ready, out_valid, out_data, key_loaded, err
    );

    modport slave (
        input  in_valid, in_is_key, in_data, resync, out_ready,
        output in_ready, out_valid, out_data, key_loaded, err
    );

endinterface

// File: rtl/xor_key_bank.sv
// rtl/xor_key_bank.sv - key storage, working schedule and rotating key index
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_en        : write wr_data into key[wr_idx]; kidx becomes wr_idx+1
//   wr_idx       : key write index
//   wr_data      : key byte
//   advance      : step kidx modulo KEY_LEN; on wrap optionally rotate schedule
//   restore      : kidx to 0, schedule reloaded from key (sees a same-cycle write)
//   kidx         : current key index
//   sched_byte   : schedule byte at the current index
module xor_key_bank
    import xor_cipher_pkg::*;
#(
    parameter int KEY_LEN = 4,
    parameter int ROTATE  = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en,
    input  kidx_t wr_idx,
    input  byte_t wr_data,
    input  logic  advance,
    input  logic  restore,
    output kidx_t kidx,
    output byte_t sched_byte
);

    localparam kidx_t LAST = kidx_t'(KEY_LEN - 1);

    key_bank_t key_q, key_d;
    key_bank_t sched_q, sched_d;
    kidx_t     kidx_q, kidx_d;

    always_comb begin
        key_d   = key_q;
        sched_d = sched_q;
        kidx_d  = kidx_q;
        if (wr_en) begin
            key_d[wr_idx] = wr_data;
        end
        // restore uses key_d so the last byte of a load lands in the schedule
        if (restore) begin
            sched_d = key_d;
            kidx_d  = '0;
        end else if (wr_en) begin
            kidx_d = kidx_t'(wr_idx + kidx_t'(1));
        end else if (advance) begin
            if (kidx_q == LAST) begin
                kidx_d = '0;
                if (ROTATE != 0) begin
                    for (int i = 0; i < KEY_LEN_MAX; i++) begin
                        sched_d[i] = rotl1(sched_q[i]);
                    end
                end
            end else begin
                kidx_d = kidx_t'(kidx_q + kidx_t'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '{default: '0};
            sched_q <= '{default: '0};
            kidx_q  <= '0;
        end else begin
            key_q   <= key_d;
            sched_q <= sched_d;
            kidx_q  <= kidx_d;
        end
    end

    assign kidx       = kidx_q;
    assign sched_byte = sched_q[kidx_q];

endmodule

// File: rtl/xor_cipher_ctrl.sv
// rtl/xor_cipher_ctrl.sv - xor cipher sequencer: key load FSM, error flag, output register
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : xor_cipher_ctrl_if.slave (input byte stream, resync, ciphertext stream, status)
// Parameters: KEY_LEN (1..8 key bytes), ROTATE (1 = rotate schedule left on each index wrap)
module xor_cipher_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int KEY_LEN = 4,
    parameter int ROTATE  = 0
) (
    input logic                clk,
    input logic                rst_n,
    xor_cipher_ctrl_if.slave   bus
);

    localparam kidx_t LAST = kidx_t'(KEY_LEN - 1);

    state_t state_q, state_d;
    logic   out_valid_q;
    byte_t  out_data_q;
    logic   err_q;

    logic   accept;
    logic   data_acc;
    logic   err_set;
    logic   bank_wr;
    kidx_t  bank_wr_idx;
    logic   bank_restore;
    logic   bank_advance;
    kidx_t  kidx;
    byte_t  sched_byte;

    xor_key_bank #(
        .KEY_LEN (KEY_LEN),
        .ROTATE  (ROTATE)
    ) u_key_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bank_wr),
        .wr_idx     (bank_wr_idx),
        .wr_data    (bus.in_data),
        .advance    (bank_advance),
        .restore    (bank_restore),
        .kidx       (kidx),
        .sched_byte (sched_byte)
    );

    // Outside RUN the output register is never loaded, so bytes are always taken.
    assign bus.in_ready = !bus.resync &&
                          ((state_q != RUN) || !out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d      = state_q;
        bank_wr      = 1'b0;
        bank_wr_idx  = '0;
        bank_restore = 1'b0;
        bank_advance = 1'b0;
        data_acc     = 1'b0;
        err_set      = 1'b0;
        if (bus.resync) begin
            bank_restore = 1'b1;
            if (state_q == LOAD) begin
                state_d = EMPTY;
            end
        end else if (accept) begin
            if (bus.in_is_key) begin
                bank_wr = 1'b1;
                if (state_q == LOAD) begin
                    bank_wr_idx = kidx;
                    if (kidx == LAST) begin
                        bank_restore = 1'b1;
                        state_d      = RUN;
                    end
                end else begin
                    // EMPTY, or RUN restarting a load: always begins at key[0]
                    bank_wr_idx = '0;
                    if (KEY_LEN == 1) begin
                        bank_restore = 1'b1;
                        state_d      = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end else if (state_q == RUN) begin
                data_acc     = 1'b1;
                bank_advance = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= data_acc || (out_valid_q && !bus.out_ready);
            if (data_acc) begin
                out_data_q <= bus.in_data ^ sched_byte;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.err        = err_q;
    assign bus.key_loaded = (state_q == RUN);

endmodule

// File: doc/xor_cipher_ctrl.md
# xor_cipher_ctrl

Sequencing controller for the XOR cipher datapath in the TinyTapeout top. Owns the key bank, loads a multi-byte key from the input byte stream, and steps a rotating key index across data bytes, with an optional per-wrap key schedule. Presents ciphertext through a one-entry registered valid/ready output stage that absorbs backpressure. Sits between the top-level pin mux (`ui_in`/`uio_in` decode) and `uo_out`.

## Interface
- `KEY_LEN`, default 4: number of key bytes, legal range 1..8.
- `ROTATE`, default 0: 1 enables the key schedule, where every key byte rotates left 1 bit on each index wrap.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  byte offered on `in_data`
- `in_is_key`  in  1  qualifies `in_data`: 1 = key byte, 0 = data byte
- `in_data`  in  8  key or plaintext byte
- `in_ready`  out  1  controller accepts the byte this cycle
- `resync`  in  1  synchronous pulse: index to 0, schedule restored to the loaded key
- `out_valid`  out  1  `out_data` holds a ciphertext byte
- `out_data`  out  8  ciphertext byte
- `out_ready`  in  1  consumer takes `out_data` this cycle
- `key_loaded`  out  1  high when state is RUN
- `err`  out  1  sticky; set when a data byte arrives without a loaded key

## Operation
- A byte is accepted when `in_valid & in_ready`.
- FSM states: EMPTY, LOAD, RUN. Reset state is EMPTY.
- **EMPTY**, key byte accepted: the byte is written to `key[0]`, `kidx` becomes 1, and the FSM moves to LOAD. If `KEY_LEN=1`, the FSM goes straight to RUN with `kidx=0`.
- **LOAD**, key byte accepted: the byte is written to `key[kidx]` and `kidx` increments. When `kidx` reaches `KEY_LEN`, the FSM moves to RUN and `kidx` becomes 0.
- **EMPTY or LOAD**, data byte accepted: the byte is discarded and `err` is set. State and `kidx` are unchanged.
- **RUN**, data byte accepted: the output register loads `in_data ^ sched[kidx]`, `out_valid` goes to 1, and `kidx` advances modulo `KEY_LEN`.
- **Key schedule (RUN):** `sched` is a working copy of `key`. On a wrap (`kidx` going `KEY_LEN-1` → 0) with `ROTATE=1`, every `sched` byte rotates left 1 bit. With `ROTATE=0`, `sched` always equals `key`.
- **RUN**, key byte accepted: this restarts a load. The byte is written to `key[0]`, `kidx` becomes 1 and the FSM moves to LOAD. A pending output byte stays valid until it is consumed.
- Completing a load copies `key` into `sched`.
- `resync` (any state) sets `kidx` to 0 and copies `key` into `sched`.
  - In LOAD, `resync` returns the FSM to EMPTY.
  - `resync` has priority over a byte accepted in the same cycle; that byte is dropped, and `in_ready` is 0 while `resync` is high.
- `err` is cleared only by reset.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=8'h00`, `err=0`, `key_loaded=0`.
  - `key`, `sched` and `kidx` all 0.
  - `in_ready=1`, with `resync` low.
- `in_ready` (combinational):
  - `!resync & (state!=RUN | !out_valid | out_ready)`.
  - There is no combinational path from `in_data` to `out_data`.
- Latency: data byte accepted in cycle N appears on `out_data` in cycle N+1, qualified by `out_valid`.
- Throughput: 1 byte per cycle while `out_ready` is held high.
- Simultaneous accept and consume: the new byte replaces the old one and `out_valid` stays 1.
- Consume without a new accept: `out_valid` goes to 0 on the next edge; `out_data` holds its last value.
- Stall: while `out_valid & !out_ready`, `out_data` and `out_valid` are stable and `in_ready` is 0 in RUN.
- Reset mid-operation: the asynchronous assert forces all reset values immediately. A pending output byte is lost.

## Structure
- **Package `xor_cipher_pkg`:**
  - state enum (EMPTY, LOAD, RUN)
  - `KEY_LEN_MAX=8`
  - byte typedef
  - key-bank array typedef
- **Sub-module `xor_key_bank`:**
  - holds `key` and `sched`, plus `kidx` and the wrap/rotate logic
  - inputs: write-enable, write index, write data, advance, restore
  - output: current schedule byte
- The top controller holds the FSM, the `err` flag and the output register.

## Test plan
- `KEY_LEN=4`, `ROTATE=0`: load key `01,02,04,08`, then send five `FF` data bytes with `out_ready=1`. Outputs must be `FE,FD,FB,F7,FE`, each one cycle after its accept.
- `ROTATE=1`, same stimulus: outputs must be `FE,FD,FB,F7,FD`, because the fifth byte uses the rotated `key[0]=02`. A `resync` before a sixth `FF` must give `FE`.
- Send data byte `55` in EMPTY: `err` must go to 1, `out_valid` must stay 0, and the state must stay EMPTY.
- In RUN, accept one byte, then hold `out_ready=0` for 3 cycles: `out_data` must be stable, `in_ready=0`, and the next offered byte must not be accepted until `out_ready=1`.
- Key byte `AA` arrives in RUN after 2 data bytes: state must go to LOAD and `key[0]=AA`. After 3 more key bytes, the next data byte must be XORed with `AA`.
- Assert `rst_n=0` mid-LOAD with `out_valid=1`: all outputs must go to their reset values immediately, and `key_loaded=0` after release.
